// File: rtl/ifetch.sv
// Instruction fetch front end: fetch PC, combinational ROM lookup and a
// two-entry {pc, instruction} buffer with redirect flush.
module ifetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2);

  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MSK = 32'hFFFF_FFFC;

  // Head entry lives directly in the output registers; tail is the second slot.
  logic [PC_W-1:0]       fetch_pc, fetch_pc_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [PC_W-1:0]       tail_pc, tail_pc_nxt;
  logic [DATA_WIDTH-1:0] tail_inst, tail_inst_nxt;
  logic [PC_W-1:0]       inst_pc_nxt;
  logic [DATA_WIDTH-1:0] inst_nxt;
  logic                  valid_nxt;
  logic                  deq;
  logic                  enq;

  // ROM word address is taken straight from the fetch PC register.
  assign imem_addr = fetch_pc[BUS_WIDTH+1:2];

  // Next-state: redirect flushes and retargets; otherwise enqueue/dequeue.
  always_comb begin
    fetch_pc_nxt  = fetch_pc;
    count_nxt     = count;
    tail_pc_nxt   = tail_pc;
    tail_inst_nxt = tail_inst;
    inst_pc_nxt   = inst_pc;
    inst_nxt      = inst;
    deq           = inst_valid & inst_ready;
    enq           = ~redirect_valid & ((count != CNT_FULL) | deq);

    if (redirect_valid) begin
      count_nxt    = CNT_EMPTY;
      fetch_pc_nxt = redirect_pc & ALIGN_MSK;
    end else if (enq) begin
      fetch_pc_nxt = fetch_pc + PC_STEP;
      case (count)
        CNT_EMPTY: begin
          inst_pc_nxt = fetch_pc;
          inst_nxt    = imem_rdata;
          count_nxt   = CNT_ONE;
        end
        CNT_ONE: begin
          if (deq) begin
            inst_pc_nxt = fetch_pc;
            inst_nxt    = imem_rdata;
          end else begin
            tail_pc_nxt   = fetch_pc;
            tail_inst_nxt = imem_rdata;
            count_nxt     = CNT_FULL;
          end
        end
        default: begin
          // Full with a dequeue: tail advances to head, new word fills tail.
          inst_pc_nxt   = tail_pc;
          inst_nxt      = tail_inst;
          tail_pc_nxt   = fetch_pc;
          tail_inst_nxt = imem_rdata;
          count_nxt     = CNT_FULL;
        end
      endcase
    end

    valid_nxt = (count_nxt != CNT_EMPTY);
  end

  // State registers; reset discards buffered entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      count      <= CNT_EMPTY;
      tail_pc    <= '0;
      tail_inst  <= '0;
      inst_pc    <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      fetch_pc   <= fetch_pc_nxt;
      count      <= count_nxt;
      tail_pc    <= tail_pc_nxt;
      tail_inst  <= tail_inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst       <= inst_nxt;
      inst_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: ROM model, directed scenarios, random traffic and a
// scoreboard of the instruction stream the consumer should observe.
module tb_ifetch;

  localparam int unsigned DW     = 32;
  localparam int unsigned BW     = 6;
  localparam int unsigned DEPTH  = 1 << BW;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst;
  logic [31:0]   inst_pc;

  logic [31:0] rom [DEPTH];

  int n_cmp = 0;
  int n_fail = 0;
  int hs_count = 0;

  // Reference model: the stream of PCs the consumer should accept next.
  logic [31:0] exp_q [$];
  logic [31:0] cursor = RST_PC;
  logic [31:0] e;
  bit          r1 = 1'b0, r2 = 1'b0, p_adv = 1'b0, p_stall = 1'b0;
  logic [31:0] r1_tgt = '0, r2_tgt = '0, s_pc = '0, s_inst = '0;

  ifetch #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  function automatic logic [31:0] rom_at(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[BW+1:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable here, so this sees exactly what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cursor  = RST_PC;
      r1      = 1'b0;
      r2      = 1'b0;
      p_adv   = 1'b0;
      p_stall = 1'b0;
    end else begin
      if (r2) begin
        check("redir_valid_2cyc", 32'(inst_valid), 32'd1);
        check("redir_pc_2cyc", inst_pc, r2_tgt);
      end
      if (r1) begin
        check("redir_flush", 32'(inst_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'(r1_tgt[BW+1:2]));
      end
      if (p_adv) check("valid_after_edge", 32'(inst_valid), 32'd1);
      if (p_stall) begin
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_pc", inst_pc, s_pc);
        check("stall_inst", inst, s_inst);
      end
      if (inst_valid && inst_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h expected none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", inst_pc, e);
          check("sb_inst", inst, rom_at(e));
        end
      end
      r2      = r1 && !redirect_valid;
      r2_tgt  = r1_tgt;
      r1      = redirect_valid;
      r1_tgt  = redirect_pc & 32'hFFFF_FFFC;
      p_adv   = !redirect_valid;
      p_stall = inst_valid && !inst_ready && !redirect_valid;
      s_pc    = inst_pc;
      s_inst  = inst;
      if (redirect_valid) begin
        exp_q.delete();
        cursor = r1_tgt;
      end
      while (exp_q.size() < 4) begin
        exp_q.push_back(cursor);
        cursor = cursor + 32'd4;
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    int r;
    for (int i = 0; i < int'(DEPTH); i++) rom[i] = 32'h1000_0000 + 32'(i);
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    #2;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(RST_PC[BW+1:2]));

    tick();
    rst_n = 1'b1;
    tick();
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_pc", inst_pc, RST_PC);
    check("first_inst", inst, rom_at(RST_PC));

    // Backpressure then streaming.
    repeat (5) tick();
    check("bp_pc", inst_pc, 32'd0);
    check("bp_addr", 32'(imem_addr), 32'd2);
    inst_ready = 1'b1;
    repeat (6) tick();

    // Redirect while full.
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0026;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid0", 32'(inst_valid), 32'd0);
    check("rd_addr", 32'(imem_addr), 32'd9);
    tick();
    check("rd_valid1", 32'(inst_valid), 32'd1);
    check("rd_pc", inst_pc, 32'h24);
    check("rd_inst", inst, 32'h1000_0009);

    // Wrap at top of address space.
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr0", 32'(imem_addr), 32'd62);
    tick();
    check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    check("wrap_inst0", inst, 32'h1000_003E);
    check("wrap_addr1", 32'(imem_addr), 32'd63);
    tick();
    check("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    check("wrap_inst1", inst, 32'h1000_003F);
    check("wrap_addr2", 32'(imem_addr), 32'd0);
    tick();
    check("wrap_pc2", inst_pc, 32'h0000_0000);
    check("wrap_inst2", inst, 32'h1000_0000);

    // Asynchronous reset between edges while full.
    inst_ready = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_pc", inst_pc, 32'd0);
    check("arst_addr", 32'(imem_addr), 32'(RST_PC[BW+1:2]));
    tick();
    check("arst_hold", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("arst_rel_valid", 32'(inst_valid), 32'd1);
    check("arst_rel_pc", inst_pc, RST_PC);

    // Redirect coinciding with a handshake.
    inst_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0093;
    tick();
    redirect_valid = 1'b0;
    check("hsrd_valid0", 32'(inst_valid), 32'd0);
    tick();
    check("hsrd_valid1", 32'(inst_valid), 32'd1);
    check("hsrd_pc", inst_pc, 32'h90);
    check("hsrd_inst", inst, 32'h1000_0024);

    // Random traffic: backpressure, redirects (incl. misaligned/wrap) and resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = 1'b1;
      inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        redirect_valid = 1'b1;
        if (r < 3) redirect_pc = $urandom();
        else redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else if (r == 6) begin
        #2;
        rst_n = 1'b0;
      end
    end
    tick();
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (4) tick();

    check("handshake_volume", 32'(hs_count >= 1000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, instruction word width.
- BUS_WIDTH, 6, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- imem_addr, output, BUS_WIDTH, word address to the instruction ROM.
- imem_rdata, input, DATA_WIDTH, ROM read data; combinational, valid in the same cycle as imem_addr.
- redirect_valid, input, 1, branch/jump redirect request.
- redirect_pc, input, 32, redirect target byte address.
- inst_valid, output, 1, instruction available at the head of the buffer.
- inst_ready, input, 1, consumer accepts the head instruction.
- inst, output, DATA_WIDTH, head instruction word.
- inst_pc, output, 32, byte address of the head instruction.

Function
REQ-003 The block SHALL hold a 32-bit fetch_pc register and a 2-entry FIFO of {pc, instruction} pairs.
REQ-004 imem_addr SHALL equal fetch_pc[BUS_WIDTH+1:2], combinationally.
REQ-005 Dequeue SHALL occur on a rising edge where inst_valid && inst_ready.
- inst, inst_pc and inst_valid SHALL NOT change while inst_valid=1 and inst_ready=0, unless a redirect occurs.
REQ-006 Enqueue SHALL occur on a rising edge where redirect_valid=0 and (count<2 or a dequeue occurs that cycle).
- The entry enqueued is {fetch_pc, imem_rdata}.
- fetch_pc SHALL increment by 4 on enqueue.
REQ-007 With count=2, no dequeue and no redirect, fetch_pc and the FIFO SHALL hold.
REQ-008 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-009 inst_valid SHALL be 1 iff count>0; inst and inst_pc SHALL present the oldest entry.
REQ-010 A redirect, on a rising edge with redirect_valid=1, SHALL have priority over enqueue.
- It flushes the FIFO (count=0) and loads fetch_pc with {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
- A handshake in the same cycle counts as accepted by the consumer; no enqueue occurs that cycle.
REQ-011 Redirect timing SHALL be as follows.
- Cycle after redirect: inst_valid=0 and imem_addr reflects the target.
- Following cycle: target instruction valid; redirect-to-valid latency is 2 cycles.
REQ-012 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-013 fetch_pc SHALL wrap modulo 2^32 from 32'hFFFF_FFFC to 0.
- imem_addr SHALL wrap modulo 2^BUS_WIDTH with no special handling.
REQ-014 Steady-state throughput with inst_ready held at 1 SHALL be one instruction per cycle.
REQ-015 The block SHALL have no combinational path from inst_ready or redirect_valid to any output.

Reset
REQ-016 On rst_n=0, asynchronously: fetch_pc=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0.
REQ-017 While rst_n=0: no enqueue or dequeue; imem_addr=RESET_PC[BUS_WIDTH+1:2].
REQ-018 rst_n asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-019 After rst_n deasserts, the first enqueue SHALL occur on the first rising edge; inst_valid=1 one cycle after release.

Verification
REQ-020 Reset/streaming: ROM[i]=32'h1000_0000+i, RESET_PC=0, inst_ready=1.
- Expected: inst_pc 0,4,8,... on consecutive cycles, with inst 32'h1000_0000, 32'h1000_0001, ...
REQ-021 Backpressure: inst_ready=0 for 5 cycles after the first valid.
- Expected: inst_pc holds 0; fetch_pc stalls at 8; with inst_ready=1, pc 0,4,8 follow with no gap or duplicate.
REQ-022 Redirect: redirect_valid=1 with redirect_pc=32'h0000_0026 while count=2.
- Expected: next cycle inst_valid=0, imem_addr=9; the cycle after, inst_pc=32'h24, inst=ROM[9].
REQ-023 Wrap: redirect to 32'hFFFF_FFF8 with BUS_WIDTH=6.
- Expected: inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, with imem_addr 62, 63, 0.
REQ-024 Async reset mid-stream: rst_n low between clock edges while count=2.
- Expected: inst_valid=0 before the next edge; after release, inst_pc=RESET_PC first.
REQ-025 Redirect on a handshake cycle: inst_ready=1, redirect_valid=1 together.
- Expected: head accepted exactly once; no stale entry appears; target valid 2 cycles later.
